// File: rtl/dmux4x16_sync.sv
// Registered 1-of-OUT_W write-enable decoder: en + sel -> one-hot strobe d, plus act = |d.
// Optional build macro DMUX4X16_SYNC_R0_LOCK_EN treats index 0 as a hard-wired zero register.
module dmux4x16_sync #(
  parameter int SEL_W = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] d,
  output logic             act
);

  logic [OUT_W-1:0] next_d;
  logic             next_act;

  // Per-line equality compare: a select beyond OUT_W-1 matches no line,
  // so out-of-range indices decode to all-zero instead of wrapping.
  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    next_d = '0;
    for (int k = 0; k < OUT_W; k++) begin
      if (en && (sel == SEL_W'(k))) next_d[k] = 1'b1;
    end
`ifdef DMUX4X16_SYNC_R0_LOCK_EN
    next_d[0] = 1'b0;
`else
    next_d[0] = en && (sel == '0);
`endif
    next_act = |next_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d   <= '0;
      act <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      d   <= next_d;
      act <= next_act;
    end
  end

endmodule

// File: tb/tb_dmux4x16_sync.sv
// Directed self-checking bench for dmux4x16_sync: default 16-output instance plus
// a 10-output instance for out-of-range selects. Honours DMUX4X16_SYNC_R0_LOCK_EN.
module tb_dmux4x16_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  sel;
  logic [15:0] d16;
  logic        act16;
  logic [9:0]  d10;
  logic        act10;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmux4x16_sync #(.SEL_W(4), .OUT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .d(d16), .act(act16)
  );

  dmux4x16_sync #(.SEL_W(4), .OUT_W(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .d(d10), .act(act10)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp16;
  logic [9:0]  exp10;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    sel   = 4'h5;

    // Reset held while clocking with en=1: outputs stay clear.
    tick();
    tick();
    check("rst_d16",   32'(d16),   32'h0000);
    check("rst_act16", 32'(act16), 32'h0);
    check("rst_d10",   32'(d10),   32'h000);

    // First edge after release decodes sel=5.
    rst_n = 1'b1;
    tick();
    check("rel_d16",   32'(d16),   32'h0020);
    check("rel_act16", 32'(act16), 32'h1);
    check("rel_d10",   32'(d10),   32'h020);

    // en=0 holds everything low.
    en  = 1'b0;
    sel = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en0_d16",   32'(d16),   32'h0000);
      check("en0_act16", 32'(act16), 32'h0);
    end
    sel = 4'hF;
    tick();
    check("en0_selF_d16", 32'(d16), 32'h0000);

    // Sweep sel 1..15; 10-output instance clears for sel >= 10.
    en = 1'b1;
    for (int i = 1; i < 16; i++) begin
      sel   = 4'(i);
      exp16 = 16'h0001 << i;
      exp10 = (i < 10) ? (10'h001 << i) : 10'h000;
      tick();
      check("sweep_d16",   32'(d16),   32'(exp16));
      check("sweep_act16", 32'(act16), 32'h1);
      check("sweep_d10",   32'(d10),   32'(exp10));
      check("sweep_act10", 32'(act10), (i < 10) ? 32'h1 : 32'h0);
    end
    check("selF_d16", 32'(d16), 32'h8000);

    // Out-of-range on the 10-output instance, then its top line.
    sel = 4'hC;
    tick();
    check("oor_d10",   32'(d10),   32'h000);
    check("oor_act10", 32'(act10), 32'h0);
    sel = 4'h9;
    tick();
    check("top_d10",   32'(d10),   32'h200);
    check("top_act10", 32'(act10), 32'h1);

    // Index 0.
    sel = 4'h0;
    tick();
`ifdef DMUX4X16_SYNC_R0_LOCK_EN
    check("sel0_d16",   32'(d16),   32'h0000);
    check("sel0_act16", 32'(act16), 32'h0);
    check("sel0_d10",   32'(d10),   32'h000);
`else
    check("sel0_d16",   32'(d16),   32'h0001);
    check("sel0_act16", 32'(act16), 32'h1);
    check("sel0_d10",   32'(d10),   32'h001);
`endif

    // Mid-cycle asynchronous reset clears outputs before the next edge.
    sel = 4'h3;
    tick();
    check("pre_async_d16", 32'(d16), 32'h0008);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_d16",   32'(d16),   32'h0000);
    check("async_act16", 32'(act16), 32'h0);
    check("async_d10",   32'(d10),   32'h000);
    tick();
    check("async_hold_d16", 32'(d16), 32'h0000);
    rst_n = 1'b1;
    tick();
    check("async_rel_d16",   32'(d16),   32'h0008);
    check("async_rel_act16", 32'(act16), 32'h1);

    // One-cycle latency: a new select is not visible until the following edge.
    sel = 4'hA;
    #2;
    check("lat_before_d16", 32'(d16), 32'h0008);
    tick();
    check("lat_after_d16", 32'(d16), 32'h0400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
